// File: rtl/mc_pred_feeder.sv
// Ping-pong 4x4 block collector: packs a serial sample stream into two banks and
// presents a completed block to the MC/LC controller. Optional MC_FEED_STATS_EN adds blk_cnt.
module mc_pred_feeder #(
  parameter int unsigned SAMPLE_W    = 8,
  parameter int unsigned BLK_SAMPLES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SAMPLE_W-1:0]             in_data,
  input  logic                            src_valid,
  output logic                            src_ready,
  output logic [SAMPLE_W*BLK_SAMPLES-1:0] blk_data
`ifdef MC_FEED_STATS_EN
  ,
  output logic [15:0]                     blk_cnt
`endif
);

  localparam int unsigned BLK_W = SAMPLE_W * BLK_SAMPLES;
  localparam int unsigned IDX_W = (BLK_SAMPLES > 1) ? $clog2(BLK_SAMPLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SAMPLES - 1);

  logic [BLK_W-1:0] bank0_q, bank0_d;
  logic [BLK_W-1:0] bank1_q, bank1_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]       full_cnt_q, full_cnt_d;

  logic in_xfer_c;
  logic out_xfer_c;
  logic blk_done_c;

  // Handshake flags derive only from registered state (plus reset for in_ready).
  assign in_ready   = !reset && (full_cnt_q != 2'd2);
  assign src_ready  = (full_cnt_q != 2'd0);
  assign blk_data   = rd_bank_q ? bank1_q : bank0_q;

  assign in_xfer_c  = in_valid && in_ready;
  assign out_xfer_c = src_valid && src_ready;
  assign blk_done_c = in_xfer_c && (wr_idx_q == LAST_IDX);

  always_comb begin
    bank0_d    = bank0_q;
    bank1_d    = bank1_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_idx_d   = wr_idx_q;
    full_cnt_d = full_cnt_q;

    if (in_xfer_c) begin
      if (wr_bank_q) begin
        bank1_d[32'(wr_idx_q) * SAMPLE_W +: SAMPLE_W] = in_data;
      end else begin
        bank0_d[32'(wr_idx_q) * SAMPLE_W +: SAMPLE_W] = in_data;
      end
      if (blk_done_c) begin
        wr_idx_d  = '0;
        wr_bank_d = !wr_bank_q;
      end else begin
        wr_idx_d  = wr_idx_q + IDX_W'(1);
      end
    end

    if (out_xfer_c) begin
      rd_bank_d = !rd_bank_q;
    end

    // Completion and consumption in the same cycle cancel out.
    case ({blk_done_c, out_xfer_c})
      2'b10:   full_cnt_d = full_cnt_q + 2'd1;
      2'b01:   full_cnt_d = full_cnt_q - 2'd1;
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank0_q    <= '0;
      bank1_q    <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      full_cnt_q <= 2'd0;
    end else begin
      bank0_q    <= bank0_d;
      bank1_q    <= bank1_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_idx_q   <= wr_idx_d;
      full_cnt_q <= full_cnt_d;
    end
  end

`ifdef MC_FEED_STATS_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;

  // Free-running count of consumed blocks, wraps at 16 bits.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (out_xfer_c) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt_q <= 16'd0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_mc_pred_feeder.sv
// Directed self-checking bench for mc_pred_feeder; exercises blk_cnt when MC_FEED_STATS_EN is defined.
module tb_mc_pred_feeder;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         src_valid;
  logic         src_ready;
  logic [127:0] blk_data;
`ifdef MC_FEED_STATS_EN
  logic [15:0]  blk_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  mc_pred_feeder #(.SAMPLE_W(8), .BLK_SAMPLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .blk_data  (blk_data)
`ifdef MC_FEED_STATS_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block whose sample k equals base+k.
  function automatic logic [127:0] blk_of(input logic [7:0] base);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; src_valid = 1'b0; in_data = 8'h00;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic push_n(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; src_valid = 1'b0; in_data = 8'h55;
    step(); step();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL rst_src_ready: got %b want 0", src_ready); end
    n_vec++; if (blk_data !== 128'd0) begin n_err++; $display("FAIL rst_blk_data: got %h want 0", blk_data); end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fill();
    do_reset();
    push_n(8'h00, 15);
    n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL fill_early_src_ready: got %b want 0", src_ready); end
    in_valid = 1'b1; in_data = 8'h0F;
    step();
    in_valid = 1'b0;
    n_vec++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL fill_src_ready: got %b want 1", src_ready); end
    n_vec++; if (blk_data[7:0] !== 8'h00) begin n_err++; $display("FAIL fill_s0: got %h want 00", blk_data[7:0]); end
    n_vec++; if (blk_data[127:120] !== 8'h0F) begin n_err++; $display("FAIL fill_s15: got %h want 0f", blk_data[127:120]); end
    n_vec++; if (blk_data !== blk_of(8'h00)) begin n_err++; $display("FAIL fill_block: got %h want %h", blk_data, blk_of(8'h00)); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_n(8'h10, 32);
    in_valid = 1'b1; in_data = 8'h99;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
    n_vec++; if (blk_data !== blk_of(8'h10)) begin n_err++; $display("FAIL bp_block0: got %h want %h", blk_data, blk_of(8'h10)); end
    step();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_in_ready: got %b want 0", in_ready); end
    n_vec++; if (dut.wr_idx_q !== 4'd0) begin n_err++; $display("FAIL bp_stall_idx: got %0d want 0", dut.wr_idx_q); end
    src_valid = 1'b1;
    step();
    src_valid = 1'b0; in_valid = 1'b0;
    n_vec++; if (blk_data !== blk_of(8'h20)) begin n_err++; $display("FAIL bp_block1: got %h want %h", blk_data, blk_of(8'h20)); end
    n_vec++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL bp_src_ready: got %b want 1", src_ready); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_back: got %b want 1", in_ready); end
    src_valid = 1'b1;
    step();
    src_valid = 1'b0;
    n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", src_ready); end
  endtask

  task automatic test_stream_overlap();
    logic [7:0] prev, cur;
    do_reset();
    push_n(8'h40, 16);
    for (int b = 1; b < 4; b++) begin
      prev = 8'h40 + 8'(16 * (b - 1));
      cur  = 8'h40 + 8'(16 * b);
      push_n(cur, 15);
      n_vec++; if (blk_data !== blk_of(prev)) begin n_err++; $display("FAIL ovl_prev_blk%0d: got %h want %h", b, blk_data, blk_of(prev)); end
      in_valid = 1'b1; in_data = cur + 8'd15; src_valid = 1'b1;
      step();
      in_valid = 1'b0; src_valid = 1'b0;
      n_vec++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL ovl_src_ready%0d: got %b want 1", b, src_ready); end
      n_vec++; if (blk_data !== blk_of(cur)) begin n_err++; $display("FAIL ovl_blk%0d: got %h want %h", b, blk_data, blk_of(cur)); end
      n_vec++; if (dut.full_cnt_q !== 2'd1) begin n_err++; $display("FAIL ovl_full_cnt%0d: got %0d want 1", b, dut.full_cnt_q); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ovl_in_ready%0d: got %b want 1", b, in_ready); end
    end
    src_valid = 1'b1;
    step();
    src_valid = 1'b0;
    n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL ovl_drained: got %b want 0", src_ready); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_n(8'h80, 16);
    push_n(8'h90, 7);
    reset = 1'b1;
    step();
    n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL mid_src_ready: got %b want 0", src_ready); end
    n_vec++; if (blk_data !== 128'd0) begin n_err++; $display("FAIL mid_blk_data: got %h want 0", blk_data); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    reset = 1'b0;
    #1;
    push_n(8'hA0, 15);
    n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL mid_partial: got %b want 0", src_ready); end
    push_n(8'hAF, 1);
    n_vec++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL mid_clean_ready: got %b want 1", src_ready); end
    n_vec++; if (blk_data !== blk_of(8'hA0)) begin n_err++; $display("FAIL mid_clean_blk: got %h want %h", blk_data, blk_of(8'hA0)); end
  endtask

  task automatic test_back_to_back();
    int m_idx, m_full, n_cons;
    logic exp_rdy;
    do_reset();
    m_idx = 0; m_full = 0; n_cons = 0;
    src_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      #1;
      exp_rdy = (m_full != 0);
      n_vec++; if (src_ready !== exp_rdy) begin n_err++; $display("FAIL b2b_src_ready cyc%0d: got %b want %b", i, src_ready, exp_rdy); end
      if (src_valid && src_ready) begin
        n_vec++; if (blk_data !== blk_of(8'(n_cons * 16))) begin n_err++; $display("FAIL b2b_blk%0d: got %h want %h", n_cons, blk_data, blk_of(8'(n_cons * 16))); end
        n_cons++;
      end
      m_full = m_full + ((m_idx == 15) ? 1 : 0) - (exp_rdy ? 1 : 0);
      m_idx  = (m_idx + 1) % 16;
      step();
    end
    src_valid = 1'b0; in_valid = 1'b0;
    n_vec++; if (n_cons != 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", n_cons); end
  endtask

`ifdef MC_FEED_STATS_EN
  task automatic test_stats();
    do_reset();
    n_vec++; if (blk_cnt !== 16'd0) begin n_err++; $display("FAIL stats_rst: got %0d want 0", blk_cnt); end
    for (int b = 0; b < 3; b++) begin
      push_n(8'(16 * b), 16);
      src_valid = 1'b1;
      step();
      src_valid = 1'b0;
    end
    n_vec++; if (blk_cnt !== 16'd3) begin n_err++; $display("FAIL stats_cnt: got %0d want 3", blk_cnt); end
    do_reset();
    n_vec++; if (blk_cnt !== 16'd0) begin n_err++; $display("FAIL stats_cnt_rst: got %0d want 0", blk_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; src_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_fill();
    test_backpressure();
    test_stream_overlap();
    test_reset_mid();
    test_back_to_back();
`ifdef MC_FEED_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
